// File: rtl/nibble_serial_adder.sv
// Serial WIDTH-bit adder/subtractor. It feeds one 4-bit ripple-carry slice one
// nibble per cycle and keeps the carry registered between nibbles.

module full_adder4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic [4:0] c;

    assign c[0] = cin;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_bit
            assign sum[gi]  = a[gi] ^ b[gi] ^ c[gi];
            assign c[gi+1]  = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign cout = c[4];
endmodule

module nibble_serial_adder #(
    parameter int WIDTH   = 16,
    parameter int NIBBLES = WIDTH / 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             Sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Carry,
    output logic             Overflow
);
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        DONE
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] a_reg, a_next;
    logic [WIDTH-1:0] b_reg, b_next;      // holds B, or ~B for subtraction
    logic [WIDTH-1:0] sum_reg, sum_next;
    logic [IDX_W-1:0] idx_reg, idx_next;
    logic             carry_reg, carry_next;
    logic             cout_reg, cout_next;
    logic             ovf_reg, ovf_next;

    logic [3:0] a_nib [NIBBLES];
    logic [3:0] b_nib [NIBBLES];
    logic [3:0] fa_a, fa_b, fa_sum;
    logic       fa_cout;

    genvar gi;
    generate
        for (gi = 0; gi < NIBBLES; gi++) begin : g_nib
            assign a_nib[gi] = a_reg[4*gi +: 4];
            assign b_nib[gi] = b_reg[4*gi +: 4];
        end
    endgenerate

    assign fa_a = a_nib[idx_reg];
    assign fa_b = b_nib[idx_reg];

    full_adder4bit u_slice (
        .a    (fa_a),
        .b    (fa_b),
        .cin  (carry_reg),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    always_comb begin
        state_next = state_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        sum_next   = sum_reg;
        idx_next   = idx_reg;
        carry_next = carry_reg;
        cout_next  = cout_reg;
        ovf_next   = ovf_reg;

        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    a_next     = A;
                    b_next     = Sub ? ~B : B;
                    carry_next = Sub ? 1'b1 : Cin;
                    idx_next   = '0;
                    state_next = ADD;
                end
            end
            ADD: begin
                for (int i = 0; i < NIBBLES; i++) begin
                    if (idx_reg == IDX_W'(i)) begin
                        sum_next[4*i +: 4] = fa_sum;
                    end
                end
                carry_next = fa_cout;
                idx_next   = idx_reg + 1'b1;
                if (idx_reg == LAST_IDX) begin
                    // Carry into the MSB is a^b^sum of that bit; overflow is it xor carry out.
                    cout_next  = fa_cout;
                    ovf_next   = a_reg[WIDTH-1] ^ b_reg[WIDTH-1] ^ fa_sum[3] ^ fa_cout;
                    idx_next   = '0;
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            idx_reg   <= '0;
            carry_reg <= 1'b0;
            cout_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            sum_reg   <= sum_next;
            idx_reg   <= idx_next;
            carry_reg <= carry_next;
            cout_reg  <= cout_next;
            ovf_reg   <= ovf_next;
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign Sum       = sum_reg;
    assign Carry     = cout_reg;
    assign Overflow  = ovf_reg;
endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
- Multi-cycle WIDTH-bit adder/subtractor that feeds the existing 4-bit ripple-carry adder one nibble per cycle.
- The carry is held in a register between nibbles.
- Operands and results use a valid/ready handshake, so wide arithmetic can reuse one 4-bit adder slice instead of a full-width carry chain.
- Sits directly upstream of one full_adder4bit instance, which is the only arithmetic datapath.

Parameters:
- WIDTH, 16: operand/result width in bits; must be a multiple of 4 and at least 4.
- NIBBLES, WIDTH/4: derived; number of ADD cycles per operation. Not to be overridden.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  operand set presented.
- in_ready  output  1  block can accept operands.
- A  input  WIDTH  operand A, unsigned or two's complement.
- B  input  WIDTH  operand B.
- Cin  input  1  carry-in for add; ignored when Sub=1.
- Sub  input  1  0: A+B+Cin; 1: A+~B+1 (A−B).
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- Sum  output  WIDTH  result.
- Carry  output  1  carry out of bit WIDTH−1. For Sub=1, Carry=1 means no borrow (A>=B unsigned).
- Overflow  output  1  two's-complement overflow.

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values (at the clk edge with rst=1): state=IDLE, nibble index=0, carry reg=0, Sum=0, Carry=0, Overflow=0, out_valid=0.
  - in_ready=1 from the first cycle after reset deasserts.
- rst overrides everything, including mid-ADD or DONE. The operation is aborted, no out_valid is produced, and the result is lost.
- in_ready = (state==IDLE), combinational from the state register. out_valid = (state==DONE), registered.
- States:
  - IDLE: on in_valid&&in_ready at an edge:
    - Latch A.
    - Latch B, or ~B when Sub=1.
    - Carry reg = Sub ? 1 : Cin.
    - Index = 0; go to ADD.
    - in_valid while in_ready=0 is ignored, with no side effects.
  - ADD: each cycle, drive nibble[index] of the latched A and B' plus the carry reg into full_adder4bit. At the edge:
    - Write its Sum into Sum[4*index+3:4*index].
    - Carry reg = adder carry out.
    - Index++.
    - On the edge that processes index NIBBLES−1: Carry = adder carry out; Overflow = A[W−1] ^ B'[W−1] ^ Sum[W−1] ^ carry out, using the new Sum bit; go to DONE.
  - DONE: Sum, Carry and Overflow held stable while out_valid=1 and out_ready=0. On out_valid&&out_ready at an edge, go to IDLE. Sum, Carry and Overflow retain their values until the next operation overwrites them.
- Latency: if operands are accepted at edge E, out_valid is high in the cycle after edge E+NIBBLES. For WIDTH=16 that is 4 edges after accept.
- Minimum initiation interval: NIBBLES+2 cycles (IDLE accept, NIBBLES ADD cycles, at least one DONE cycle). No overlap: in_ready=0 in ADD and DONE, even when out_ready is high in DONE.
- Arithmetic:
  - Result is modulo 2^WIDTH.
  - Carry/borrow is as defined under Ports.
  - Carry propagates only through the registered carry between nibbles, never combinationally across more than one nibble.
- Operands A, B, Cin and Sub may change or go X after acceptance without affecting the result.
- Sum bits of nibbles not yet processed hold stale data during ADD. Only values qualified by out_valid are defined.
- WIDTH=4: a single ADD cycle, then DONE.

Test Plan:
- Reset, then idle: rst high 2 cycles, then low → in_ready=1, out_valid=0, Sum=0, Carry=0, Overflow=0.
- Add with full carry chain: A=16'hFFFF, B=16'h0001, Cin=0, Sub=0, accepted at edge E → out_valid rises after E+4; Sum=16'h0000, Carry=1, Overflow=0. in_ready=0 during ADD/DONE.
- Subtract and signed overflow:
  - A=16'h0005, B=16'h0007, Sub=1 → Sum=16'hFFFE, Carry=0 (borrow), Overflow=0.
  - A=16'h7FFF, B=16'h0001, Sub=0 → Sum=16'h8000, Carry=0, Overflow=1.
- Output backpressure: A=16'h1234, B=16'h1111, Cin=1, with out_ready held low 5 cycles after out_valid → Sum=16'h2346 and Carry=0 stable throughout. Operands changed and in_valid kept high during DONE are ignored. Handshake completes when out_ready=1; in_ready=1 the next cycle.
- Reset mid-operation: accept A=16'hABCD, B=16'h1111, assert rst at the 2nd ADD edge → state IDLE, out_valid never asserts, Sum=0. A following op A=16'h0001, B=16'h0002 yields Sum=16'h0003.
- Back-to-back plus WIDTH=4 instance: two ops with out_ready tied high complete with initiation interval = 6 cycles. For WIDTH=4, A=4'hF, B=4'hF, Cin=1 → Sum=4'hF, Carry=1, out_valid after 1 ADD edge.
